// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Shifts run iteratively, up to SHIFT_STEP bits per cycle. Every other
// operation, and any shift by zero, completes in a single cycle.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | accepts a new operation when the output register is free
//   S_SHIFT | iterating a shift; sh_cnt holds the bits still to be shifted
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_control_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic [4:0]            rd_addr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic [4:0]            rd_addr_o
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_kind_t;

  state_t                state;
  sh_kind_t              sh_kind;
  logic [DATA_WIDTH-1:0] sh_val;
  logic [4:0]            sh_tag;
  logic [SW-1:0]         sh_cnt;

  logic [SW-1:0]         shamt;
  logic                  is_shift;
  logic                  accept;
  sh_kind_t              ctrl_kind;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [SW-1:0]         step;
  logic [SW-1:0]         sh_next_cnt;
  logic [DATA_WIDTH-1:0] sh_next_val;

  function automatic logic [DATA_WIDTH-1:0] shift_by(input sh_kind_t kind,
                                                     input logic [DATA_WIDTH-1:0] v,
                                                     input logic [SW-1:0] amt);
    logic signed [DATA_WIDTH-1:0] sv;
    sv = $signed(v);
    case (kind)
      SH_LL:   return v << amt;
      SH_RL:   return v >> amt;
      default: return sv >>> amt;
    endcase
  endfunction

  assign shamt      = op_b_i[SW-1:0];
  assign is_shift   = (alu_control_i == 4'b0101) || (alu_control_i == 4'b0110) ||
                      (alu_control_i == 4'b0111);
  assign in_ready_o = (state == S_IDLE) && !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Shift flavour derived from the opcode, used both for one-cycle and iterative shifts
  always_comb begin
    ctrl_kind = SH_RA;
    if (alu_control_i == 4'b0101) ctrl_kind = SH_LL;
    else if (alu_control_i == 4'b0110) ctrl_kind = SH_RL;
  end

  // Single-cycle result; codes 1010-1111 fall through to ADD
  always_comb begin
    alu_res = op_a_i + op_b_i;
    case (alu_control_i)
      4'b0001: alu_res = op_a_i - op_b_i;
      4'b0010: alu_res = op_a_i & op_b_i;
      4'b0011: alu_res = op_a_i | op_b_i;
      4'b0100: alu_res = op_a_i ^ op_b_i;
      4'b0101, 4'b0110, 4'b0111: alu_res = shift_by(ctrl_kind, op_a_i, shamt);
      4'b1000: alu_res = DATA_WIDTH'($signed(op_a_i) < $signed(op_b_i));
      4'b1001: alu_res = DATA_WIDTH'(op_a_i < op_b_i);
      default: alu_res = op_a_i + op_b_i;
    endcase
  end

  // One iteration of the shifter: min(cnt, STEP) bits this cycle
  always_comb begin
    step        = (sh_cnt < STEP) ? sh_cnt : STEP;
    sh_next_cnt = sh_cnt - step;
    sh_next_val = shift_by(sh_kind, sh_val, step);
  end

  // FSM, shifter registers and output register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      sh_kind     <= SH_LL;
      sh_val      <= '0;
      sh_tag      <= '0;
      sh_cnt      <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b1;
      rd_addr_o   <= '0;
    end else if (flush_i) begin
      // result_o/zero_o/rd_addr_o deliberately keep their last value
      state       <= S_IDLE;
      sh_cnt      <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              sh_val  <= op_a_i;
              sh_kind <= ctrl_kind;
              sh_tag  <= rd_addr_i;
              sh_cnt  <= shamt;
              state   <= S_SHIFT;
            end else begin
              result_o    <= alu_res;
              zero_o      <= (alu_res == '0);
              rd_addr_o   <= rd_addr_i;
              out_valid_o <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          sh_val <= sh_next_val;
          sh_cnt <= sh_next_cnt;
          if (sh_next_cnt == '0) begin
            result_o    <= sh_next_val;
            zero_o      <= (sh_next_val == '0);
            rd_addr_o   <= sh_tag;
            out_valid_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
